uart_rx_frame_ctrl: RTL

Receive-side framing controller for the UART. It consumes the byte stream produced by the UART receiver (`rx_byte_valid` / `rx_byte_data` / `rx_active`) and parses frames of the form SOF, LEN, payload, checksum. Payload bytes are buffered internally and released downstream on a valid/ready stream only after the checksum verifies. The block sits between the UART receiver and the command/processing logic, and reports framing errors and inter-byte timeouts.

---
 rtl/uart_rx_frame_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Receive-side frame parser for SOF, LEN, payload, checksum. The payload is held in a
// local buffer and streamed out only after the checksum has verified.
module uart_rx_frame_ctrl #(
    parameter int                   PACK_SIZE   = 8,
    parameter int                   MAX_LEN     = 16,
    parameter logic [PACK_SIZE-1:0] SOF         = 8'hA5,
    parameter int                   TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_byte_valid,
    input  logic [PACK_SIZE-1:0] rx_byte_data,
    input  logic                 rx_active,
    output logic                 out_valid,
    output logic [PACK_SIZE-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 pkt_ok,
    output logic                 pkt_err,
    output logic [1:0]           err_code,
    output logic                 busy
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [PACK_SIZE-1:0] LEN_MAX  = PACK_SIZE'(MAX_LEN);
    localparam logic [PACK_SIZE-1:0] BYTE_ONE = PACK_SIZE'(1);
    // The status pulse is registered, so the abort is decided one idle cycle
    // early; the pulse then lands TIMEOUT_CYC cycles after the last activity.
    localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYC - 2);
    localparam logic [TW-1:0]        TMO_ONE  = TW'(1);

    localparam logic [1:0] ERR_CSUM    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t               state_reg;
    logic [PACK_SIZE-1:0] len_reg;
    logic [PACK_SIZE-1:0] sum_reg;
    logic [PACK_SIZE-1:0] idx_reg;
    logic [PACK_SIZE-1:0] rd_idx_reg;
    logic [TW-1:0]        tmo_cnt_reg;
    logic                 out_valid_reg;
    logic                 out_last_reg;
    logic                 pkt_ok_reg;
    logic                 pkt_err_reg;
    logic [1:0]           err_code_reg;
    logic                 busy_reg;

    logic [PACK_SIZE-1:0] buf_mem [MAX_LEN];
    logic [PACK_SIZE-1:0] rd_data_reg;

    logic                 timed_state;
    logic                 idle_cycle;
    logic                 tmo_hit;
    logic                 handshake;
    logic [PACK_SIZE-1:0] sum_next;
    logic                 csum_good;
    logic [PACK_SIZE-1:0] rd_idx_next;
    logic                 wr_en;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;

    assign timed_state = (state_reg == S_LEN) || (state_reg == S_PAYLOAD) || (state_reg == S_CSUM);
    assign idle_cycle  = timed_state && !rx_byte_valid && !rx_active;
    assign tmo_hit     = idle_cycle && (tmo_cnt_reg == TMO_LAST);
    assign handshake   = out_valid_reg && out_ready;
    assign sum_next    = sum_reg + rx_byte_data;
    assign csum_good   = (sum_next == '0);
    assign rd_idx_next = rd_idx_reg + BYTE_ONE;

    // Buffer reads are registered: buf[0] is fetched while the checksum byte is
    // accepted, later entries on each handshake that is not the final one.
    assign wr_en   = (state_reg == S_PAYLOAD) && rx_byte_valid;
    assign rd_en   = ((state_reg == S_CSUM) && rx_byte_valid && csum_good)
                   || ((state_reg == S_DRAIN) && handshake && !out_last_reg);
    assign rd_addr = (state_reg == S_DRAIN) ? rd_idx_next[AW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[idx_reg[AW-1:0]] <= rx_byte_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= buf_mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !idle_cycle) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            sum_reg       <= '0;
            idx_reg       <= '0;
            rd_idx_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            pkt_ok_reg    <= 1'b0;
            pkt_err_reg   <= 1'b0;
            err_code_reg  <= ERR_CSUM;
            busy_reg      <= 1'b0;
        end else begin
            pkt_ok_reg  <= 1'b0;
            pkt_err_reg <= 1'b0;

            unique case (state_reg)
                S_IDLE: begin
                    if (rx_byte_valid && (rx_byte_data == SOF)) begin
                        state_reg <= S_LEN;
                        busy_reg  <= 1'b1;
                    end
                end

                S_LEN: begin
                    if (rx_byte_valid) begin
                        len_reg <= rx_byte_data;
                        sum_reg <= rx_byte_data;
                        idx_reg <= '0;
                        if (rx_byte_data > LEN_MAX) begin
                            pkt_err_reg  <= 1'b1;
                            err_code_reg <= ERR_LEN;
                            state_reg    <= S_IDLE;
                            busy_reg     <= 1'b0;
                        end else if (rx_byte_data == '0) begin
                            state_reg <= S_CSUM;
                        end else begin
                            state_reg <= S_PAYLOAD;
                        end
                    end else if (tmo_hit) begin
                        pkt_err_reg  <= 1'b1;
                        err_code_reg <= ERR_TIMEOUT;
                        state_reg    <= S_IDLE;
                        busy_reg     <= 1'b0;
                    end
                end

                S_PAYLOAD: begin
                    if (rx_byte_valid) begin
                        sum_reg <= sum_next;
                        idx_reg <= idx_reg + BYTE_ONE;
                        if ((idx_reg + BYTE_ONE) == len_reg) begin
                            state_reg <= S_CSUM;
                        end
                    end else if (tmo_hit) begin
                        pkt_err_reg  <= 1'b1;
                        err_code_reg <= ERR_TIMEOUT;
                        state_reg    <= S_IDLE;
                        busy_reg     <= 1'b0;
                    end
                end

                S_CSUM: begin
                    if (rx_byte_valid) begin
                        if (csum_good) begin
                            pkt_ok_reg <= 1'b1;
                            if (len_reg == '0) begin
                                state_reg <= S_IDLE;
                                busy_reg  <= 1'b0;
                            end else begin
                                state_reg     <= S_DRAIN;
                                rd_idx_reg    <= '0;
                                out_valid_reg <= 1'b1;
                                out_last_reg  <= (len_reg == BYTE_ONE);
                            end
                        end else begin
                            pkt_err_reg  <= 1'b1;
                            err_code_reg <= ERR_CSUM;
                            state_reg    <= S_IDLE;
                            busy_reg     <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        pkt_err_reg  <= 1'b1;
                        err_code_reg <= ERR_TIMEOUT;
                        state_reg    <= S_IDLE;
                        busy_reg     <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    // Bytes arriving while draining are dropped, SOF included.
                    if (rx_byte_valid) begin
                        pkt_err_reg  <= 1'b1;
                        err_code_reg <= ERR_OVERRUN;
                    end
                    if (handshake) begin
                        if (out_last_reg) begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            state_reg     <= S_IDLE;
                            busy_reg      <= 1'b0;
                        end else begin
                            rd_idx_reg   <= rd_idx_next;
                            out_last_reg <= ((rd_idx_next + BYTE_ONE) == len_reg);
                        end
                    end
                end

                default: begin
                    state_reg     <= S_IDLE;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = rd_data_reg;
    assign out_last  = out_last_reg;
    assign pkt_ok    = pkt_ok_reg;
    assign pkt_err   = pkt_err_reg;
    assign err_code  = err_code_reg;
    assign busy      = busy_reg;

endmodule
